// File: rtl/msg_schedule_pkg.sv
// Shared definitions for the SHA-2 message schedule: codec decode, FSM states
// and block/round constants, also used by the hash core.
package msg_schedule_pkg;

    localparam int BLOCK512_WORDS    = 16;
    localparam int BLOCK1024_WORDS   = 16;
    localparam int ROUNDS_SHA256     = 64;
    localparam int ROUNDS_SHA512     = 80;
    localparam int CODEC_TUSER_WIDTH = 128;

    // Multiformats multihash codes carried in tuser[15:0]
    localparam logic [15:0] CODEC_SHA2_256 = 16'h0012;
    localparam logic [15:0] CODEC_SHA2_512 = 16'h0013;
    localparam logic [15:0] CODEC_SHA2_384 = 16'h0020;
    localparam logic [15:0] CODEC_SHA2_224 = 16'h1013;

    typedef enum logic [1:0] {
        SHA_224 = 2'b00,
        SHA_256 = 2'b01,
        SHA_384 = 2'b10,
        SHA_512 = 2'b11
    } sha_type_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOAD   = 2'b01,
        ST_EXPAND = 2'b10
    } state_e;

    function automatic logic [15:0] extract_codec(input logic [CODEC_TUSER_WIDTH-1:0] tuser);
        return 16'(tuser);
    endfunction

    function automatic sha_type_e codec_to_sha_type(input logic [15:0] codec);
        sha_type_e st;
        case (codec)
            CODEC_SHA2_224: st = SHA_224;
            CODEC_SHA2_256: st = SHA_256;
            CODEC_SHA2_384: st = SHA_384;
            CODEC_SHA2_512: st = SHA_512;
            default:        st = SHA_224;
        endcase
        return st;
    endfunction

    function automatic logic [6:0] rounds_for(input sha_type_e st);
        return (st == SHA_384 || st == SHA_512) ? 7'(ROUNDS_SHA512) : 7'(ROUNDS_SHA256);
    endfunction

endpackage

// File: rtl/msg_schedule_sched_sigma.sv
// Small sigma functions of the SHA-2 schedule; 32-bit results are zero-extended.
module sched_sigma (
    input  logic        mode64_i,
    input  logic [63:0] x15_i,
    input  logic [63:0] x2_i,
    output logic [63:0] s0_o,
    output logic [63:0] s1_o
);

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // s0 from W[t-15], s1 from W[t-2]
    always_comb begin
        s0_o = 64'd0;
        s1_o = 64'd0;
        if (mode64_i) begin
            s0_o = rotr64(x15_i, 1) ^ rotr64(x15_i, 8) ^ (x15_i >> 7);
            s1_o = rotr64(x2_i, 19) ^ rotr64(x2_i, 61) ^ (x2_i >> 6);
        end else begin
            s0_o = {32'd0, rotr32(x15_i[31:0], 7) ^ rotr32(x15_i[31:0], 18) ^ (x15_i[31:0] >> 3)};
            s1_o = {32'd0, rotr32(x2_i[31:0], 17) ^ rotr32(x2_i[31:0], 19) ^ (x2_i[31:0] >> 10)};
        end
    end

endmodule

// File: rtl/msg_schedule.sv
// SHA-2 message schedule: loads 16 padded words per block over AXI-Stream and
// emits 64 or 80 Wt words, one per output advance.
module msg_schedule
    import msg_schedule_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH = 64,
    parameter int C_M_AXIS_DATA_WIDTH = 64,
    parameter int C_AXIS_TUSER_WIDTH  = 128
) (
    input  logic                           axis_aclk,
    input  logic                           reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]  s_axis_tuser,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic                           s_axis_tlast,
    output logic [C_M_AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [C_AXIS_TUSER_WIDTH-1:0]  m_axis_tuser,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast
);

    state_e                        state_q;
    sha_type_e                     sha_type_q;
    logic [C_AXIS_TUSER_WIDTH-1:0] tuser_q;
    logic [15:0][63:0]             win_q;
    logic [6:0]                    t_q;
    logic                          final_q;
    logic [63:0]                   m_tdata_q;
    logic [C_AXIS_TUSER_WIDTH-1:0] m_tuser_q;
    logic                          m_tvalid_q;
    logic                          m_tlast_q;

    logic        mode64_s;
    logic        adv_s;
    logic        s_hs_s;
    logic        load_last_s;
    logic        last_round_s;
    logic [63:0] s_word_s;
    logic [63:0] in_word_s;
    logic [63:0] s0_s;
    logic [63:0] s1_s;
    logic [63:0] wt_sum_s;
    logic [63:0] wt_d;

    assign mode64_s      = sha_type_q[1];
    assign adv_s         = !m_tvalid_q || m_axis_tready;
    assign s_axis_tready = (state_q == ST_LOAD) && adv_s;
    assign s_hs_s        = s_axis_tready && s_axis_tvalid;
    assign load_last_s   = (t_q == (mode64_s ? 7'(BLOCK1024_WORDS - 1) : 7'(BLOCK512_WORDS - 1)));
    assign last_round_s  = (t_q == rounds_for(sha_type_q) - 7'd1);

    // win_q[15] is W[t-1], win_q[0] is W[t-16]
    sched_sigma u_sigma (
        .mode64_i (mode64_s),
        .x15_i    (win_q[1]),
        .x2_i     (win_q[14]),
        .s0_o     (s0_s),
        .s1_o     (s1_s)
    );

    // Mode-dependent masking of the loaded word and the expanded sum
    always_comb begin
        s_word_s = 64'(s_axis_tdata);
        wt_sum_s = s1_s + win_q[9] + s0_s + win_q[0];
        if (mode64_s) begin
            in_word_s = s_word_s;
            wt_d      = wt_sum_s;
        end else begin
            in_word_s = {32'd0, s_word_s[31:0]};
            wt_d      = {32'd0, wt_sum_s[31:0]};
        end
    end

    // Control FSM, window shift and registered output stage
    always_ff @(posedge axis_aclk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sha_type_q <= SHA_224;
            tuser_q    <= '0;
            win_q      <= '0;
            t_q        <= 7'd0;
            final_q    <= 1'b0;
            m_tdata_q  <= 64'd0;
            m_tuser_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
        end else begin
            if (m_tvalid_q && m_axis_tready) begin
                m_tvalid_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (s_axis_tvalid) begin
                        tuser_q    <= s_axis_tuser;
                        sha_type_q <= codec_to_sha_type(extract_codec(CODEC_TUSER_WIDTH'(s_axis_tuser)));
                        state_q    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (s_hs_s) begin
                        win_q      <= {in_word_s, win_q[15:1]};
                        m_tdata_q  <= in_word_s;
                        m_tuser_q  <= tuser_q;
                        m_tvalid_q <= 1'b1;
                        m_tlast_q  <= 1'b0;
                        t_q        <= t_q + 7'd1;
                        if (s_axis_tlast) begin
                            final_q <= 1'b1;
                        end
                        if (load_last_s) begin
                            state_q <= ST_EXPAND;
                        end
                    end
                end
                ST_EXPAND: begin
                    if (adv_s) begin
                        win_q      <= {wt_d, win_q[15:1]};
                        m_tdata_q  <= wt_d;
                        m_tuser_q  <= tuser_q;
                        m_tvalid_q <= 1'b1;
                        m_tlast_q  <= final_q && last_round_s;
                        if (last_round_s) begin
                            t_q     <= 7'd0;
                            final_q <= 1'b0;
                            state_q <= final_q ? ST_IDLE : ST_LOAD;
                        end else begin
                            t_q <= t_q + 7'd1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_axis_tdata  = C_M_AXIS_DATA_WIDTH'(m_tdata_q);
    assign m_axis_tuser  = m_tuser_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tlast  = m_tlast_q;

endmodule

// File: tb/tb_msg_schedule.sv
// Directed + randomized bench for msg_schedule against a plain-arithmetic
// SHA-2 schedule model with an expected-word queue.
module tb_msg_schedule;

    typedef logic [63:0] blk_t [16];
    typedef struct {
        logic [63:0]  d;
        logic         l;
        logic [127:0] u;
        bit           ex;
    } exp_t;

    logic         axis_aclk = 1'b0;
    logic         reset = 1'b1;
    logic [63:0]  s_axis_tdata = 64'd0;
    logic [127:0] s_axis_tuser = 128'd0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tready;
    logic         s_axis_tlast = 1'b0;
    logic [63:0]  m_axis_tdata;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1'b1;
    logic         m_axis_tlast;

    always #5 axis_aclk = ~axis_aclk;

    msg_schedule dut (
        .axis_aclk     (axis_aclk),
        .reset         (reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    int           checks = 0;
    int           failures = 0;
    exp_t         exp_q[$];
    logic [63:0]  got_q[$];
    bit           rand_ready = 1'b0;
    bit           gaps = 1'b0;
    bit           hs_seen = 1'b0;
    bit           stall_prev = 1'b0;
    logic [63:0]  prev_d = 64'd0;
    logic [127:0] prev_u = 128'd0;
    logic         prev_l = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input bit m64);
        logic [63:0] y;
        y = x;
        for (int i = 0; i < n; i++) begin
            if (m64) y = {y[0], y[63:1]};
            else     y = {32'd0, y[0], y[31:1]};
        end
        return y;
    endfunction

    function automatic bit is64(input logic [15:0] codec);
        return (codec == 16'h0013) || (codec == 16'h0020);
    endfunction

    task automatic model_block(input blk_t b, input bit m64, input logic [127:0] u, input bit fin);
        logic [63:0] w [80];
        logic [63:0] s0, s1, sum;
        int r;
        r = m64 ? 80 : 64;
        for (int t = 0; t < r; t++) begin
            if (t < 16) begin
                w[t] = m64 ? b[t] : {32'd0, b[t][31:0]};
            end else begin
                s0  = rotr(w[t-15], m64 ? 1 : 7, m64) ^ rotr(w[t-15], m64 ? 8 : 18, m64)
                      ^ (w[t-15] >> (m64 ? 7 : 3));
                s1  = rotr(w[t-2], m64 ? 19 : 17, m64) ^ rotr(w[t-2], m64 ? 61 : 19, m64)
                      ^ (w[t-2] >> (m64 ? 6 : 10));
                sum = s1 + w[t-7] + s0 + w[t-16];
                w[t] = m64 ? sum : {32'd0, sum[31:0]};
            end
            exp_q.push_back('{d: w[t], l: fin && (t == r - 1), u: u, ex: (t >= 15 && t <= r - 2)});
        end
    endtask

    // One clock: observe at the falling edge, then move past the rising edge.
    task automatic cycle();
        @(negedge axis_aclk);
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 128'(m_axis_tvalid), 128'd1);
                chk("hold_data", 128'(m_axis_tdata), 128'(prev_d));
                chk("hold_tuser", m_axis_tuser, prev_u);
                chk("hold_tlast", 128'(m_axis_tlast), 128'(prev_l));
            end
            if (m_axis_tvalid && exp_q.size() > 0 && exp_q[0].ex)
                chk("tready_in_expand", 128'(s_axis_tready), 128'd0);
            if (m_axis_tvalid && m_axis_tready) begin
                chk("word_expected", 128'(exp_q.size() > 0), 128'd1);
                if (exp_q.size() > 0) begin
                    chk("wt_data", 128'(m_axis_tdata), 128'(exp_q[0].d));
                    chk("wt_tlast", 128'(m_axis_tlast), 128'(exp_q[0].l));
                    chk("wt_tuser", m_axis_tuser, exp_q[0].u);
                    got_q.push_back(m_axis_tdata);
                    void'(exp_q.pop_front());
                end
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            prev_d = m_axis_tdata;
            prev_u = m_axis_tuser;
            prev_l = m_axis_tlast;
        end
        hs_seen = s_axis_tvalid && s_axis_tready;
        @(posedge axis_aclk);
        #1;
        m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic send_word(input logic [63:0] d, input logic l, input logic [127:0] u);
        int g;
        g = 0;
        if (gaps) repeat ($urandom_range(0, 1)) cycle();
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
        s_axis_tvalid = 1'b1;
        do begin
            cycle();
            g++;
        end while (!hs_seen && g < 1000);
        chk("in_handshake", 128'(hs_seen), 128'd1);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_block(input blk_t b, input bit m64, input logic [127:0] u, input int last_at);
        model_block(b, m64, u, last_at >= 0);
        for (int i = 0; i < 16; i++) send_word(b[i], i == last_at, u);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 5000) begin
            cycle();
            g++;
        end
        chk("drain_done", 128'(exp_q.size()), 128'd0);
    endtask

    task automatic rand_blk(output blk_t b);
        for (int i = 0; i < 16; i++) b[i] = {$urandom, $urandom};
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_m_tvalid"}, 128'(m_axis_tvalid), 128'd0);
        chk({tag, "_m_tlast"}, 128'(m_axis_tlast), 128'd0);
        chk({tag, "_m_tdata"}, 128'(m_axis_tdata), 128'd0);
        chk({tag, "_m_tuser"}, m_axis_tuser, 128'd0);
        chk({tag, "_s_tready"}, 128'(s_axis_tready), 128'd0);
    endtask

    task automatic chk_abc256();
        chk("abc_count", 128'(got_q.size()), 128'd64);
        chk("abc_w16", 128'(got_q[16]), 128'h61626380);
        chk("abc_w17", 128'(got_q[17]), 128'h000F0000);
        chk("abc_w18", 128'(got_q[18]), 128'h7DA86405);
        chk("abc_w19", 128'(got_q[19]), 128'h600003C6);
    endtask

    initial begin
        blk_t         abc, abc512, b;
        logic [127:0] u;
        int           lp;

        for (int i = 0; i < 16; i++) begin
            abc[i]    = 64'd0;
            abc512[i] = 64'd0;
        end
        abc[0]     = 64'h0000_0000_6162_6380;
        abc[15]    = 64'h0000_0000_0000_0018;
        abc512[0]  = 64'h6162_6380_0000_0000;
        abc512[15] = 64'h0000_0000_0000_0018;

        reset = 1'b1;
        repeat (3) cycle();
        chk_reset_outputs("reset");
        reset = 1'b0;
        cycle();
        chk("idle_tready", 128'(s_axis_tready), 128'd0);

        // SHA-256 "abc"
        got_q.delete();
        send_block(abc, 1'b0, {112'd0, 16'h0012}, 15);
        drain();
        chk_abc256();

        // SHA-512 "abc"
        got_q.delete();
        send_block(abc512, 1'b1, {112'd0, 16'h0013}, 15);
        drain();
        chk("abc512_count", 128'(got_q.size()), 128'd80);
        chk("abc512_w0", 128'(got_q[0]), 128'h6162638000000000);

        // Two-block SHA-256 message
        got_q.delete();
        u = {$urandom, $urandom, $urandom, 16'hA5C3, 16'h0012};
        rand_blk(b);
        send_block(b, 1'b0, u, -1);
        rand_blk(b);
        send_block(b, 1'b0, u, 15);
        drain();
        chk("two_block_count", 128'(got_q.size()), 128'd128);

        // Random backpressure and input gaps across modes
        rand_ready = 1'b1;
        gaps = 1'b1;
        u = {$urandom, $urandom, $urandom, 16'h0000, 16'h0020};
        rand_blk(b);
        send_block(b, is64(16'h0020), u, -1);
        rand_blk(b);
        lp = int'($urandom_range(0, 15));
        send_block(b, is64(16'h0020), u, lp);
        u = {$urandom, $urandom, $urandom, 16'h0000, 16'h1013};
        rand_blk(b);
        lp = int'($urandom_range(0, 15));
        send_block(b, is64(16'h1013), u, lp);
        u = {$urandom, $urandom, $urandom, 16'h0000, 16'h0013};
        rand_blk(b);
        send_block(b, is64(16'h0013), u, 15);
        drain();
        rand_ready = 1'b0;
        gaps = 1'b0;
        m_axis_tready = 1'b1;

        // Reset after input word 9, then a fresh "abc"
        rand_blk(b);
        u = {112'd0, 16'h0012};
        model_block(b, 1'b0, u, 1'b1);
        for (int i = 0; i < 9; i++) send_word(b[i], 1'b0, u);
        reset = 1'b1;
        cycle();
        cycle();
        exp_q.delete();
        chk_reset_outputs("midreset");
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("no_residue_tvalid", 128'(m_axis_tvalid), 128'd0);
        end
        got_q.delete();
        send_block(abc, 1'b0, {112'd0, 16'h0012}, 15);
        drain();
        chk_abc256();

        // Unsupported codec falls back to 32-bit SHA-224
        got_q.delete();
        rand_blk(b);
        send_block(b, is64(16'h0000), {112'd0, 16'h0000}, 15);
        drain();
        chk("unsupported_count", 128'(got_q.size()), 128'd64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/msg_schedule.md
MSG_SCHEDULE -- requirements
Module: msg_schedule

Interface
REQ-001 Parameter C_S_AXIS_DATA_WIDTH, default 64, width of input message-word tdata.
REQ-002 Parameter C_M_AXIS_DATA_WIDTH, default 64, width of output schedule-word (Wt) tdata.
REQ-003 Parameter C_AXIS_TUSER_WIDTH, default 128, width of tuser on both ports, which carries the multiformats codec.
REQ-004 Port list:
- axis_aclk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  64  padded message word.
- s_axis_tuser  in  128  codec/metadata.
- s_axis_tvalid  in  1
- s_axis_tready  out  1
- s_axis_tlast  in  1  final block of message.
- m_axis_tdata  out  64  Wt word to the hash core.
- m_axis_tuser  out  128
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tlast  out  1
REQ-005 Clocking and reset are fixed: reset reset, synchronous, active-high; clock axis_aclk.

Function
REQ-006 The block SHALL expand each 16-word padded block into 64 Wt words (SHA-224/256) or 80 Wt words (SHA-384/512).
REQ-007 The block SHALL decode sha_type from s_axis_tuser at the first accepted word of a message: 224=00, 256=01, 384=10, 512=11, unsupported=00; it SHALL hold sha_type until the message's last Wt word is emitted.
REQ-008 32-bit modes SHALL use tdata[31:0] only, output [63:32]=0, and add mod 2^32; 64-bit modes SHALL add mod 2^64.
REQ-009 Schedule rules:
- Wt = input word t for t<16.
- Wt = s1(Wt-2)+Wt-7+s0(Wt-15)+Wt-16 otherwise.
- 32-bit: s0=ROTR7^ROTR18^SHR3, s1=ROTR17^ROTR19^SHR10.
- 64-bit: s0=ROTR1^ROTR8^SHR7, s1=ROTR19^ROTR61^SHR6.
REQ-010 FSM states SHALL be IDLE, LOAD and EXPAND:
- IDLE->LOAD on s_axis_tvalid, latching tuser and sha_type.
- LOAD->EXPAND after the 16th input handshake.
- EXPAND->LOAD after the last Wt of a non-final block.
- EXPAND->IDLE after the last Wt of the final block.
REQ-011 Output SHALL be registered: one Wt per cycle; latency of 1 cycle from input handshake to m_axis_tvalid in LOAD.
REQ-012 s_axis_tready SHALL be 1 only in LOAD, and only when (!m_axis_tvalid || m_axis_tready); it SHALL be 0 in IDLE and EXPAND.
REQ-013 In EXPAND, a new Wt SHALL be produced only when (!m_axis_tvalid || m_axis_tready).
REQ-014 When m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata/tuser/tlast SHALL hold stable.
REQ-015 Word counter t SHALL count 0..63 or 0..79, wrap to 0 at block end, and drive the EXPAND exit.
REQ-016 s_axis_tlast sampled on any accepted word of a block SHALL mark the block final; the block still requires 16 words.
REQ-017 m_axis_tlast SHALL be 1 on the last Wt word of a final block only.
REQ-018 m_axis_tuser SHALL equal the tuser latched at message start for every Wt word of that message.
REQ-019 The 16-entry window SHALL shift only on an output advance; back-to-back blocks SHALL need no idle cycle beyond the LOAD phase.

Reset
REQ-020 On reset:
- state=IDLE, t=0, final flag=0.
- s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0.
- m_axis_tdata=0, m_axis_tuser=0.
REQ-021 Reset asserted mid-block SHALL discard the partial block and window contents; no Wt SHALL be emitted until a new message starts.

Structure
REQ-022 A shared package SHALL hold:
- codec constants and the extract_codec/codec-to-sha_type decode shared with the hash core;
- the state enum;
- the BLOCK512_WORDS/BLOCK1024_WORDS and round-count (64/80) constants.
REQ-023 One combinational sub-module, sched_sigma, SHALL compute s0/s1 with a mode64 input.

Verification
REQ-024 SHA-256 "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018, tlast on W15) -> 64 words:
- W16=0x61626380, W17=0x000F0000, W18=0x7DA86405, W19=0x600003C6;
- all words match the golden model;
- tlast only on W63.
REQ-025 SHA-512 "abc" block (W0=0x6162638000000000, W15=0x18) -> 80 words matching the golden model; tlast only on W79; upper bits used.
REQ-026 Two-block SHA-256 message -> 128 words; tlast only on word 127; tuser constant; tready low during each EXPAND.
REQ-027 Random m_axis_tready deassertion (50%) during LOAD and EXPAND -> no word lost or duplicated; data stable while stalled.
REQ-028 Reset pulsed at input word 9, then a fresh "abc" block -> output identical to REQ-024 with no residue.
REQ-029 Unsupported codec (0x0000) -> treated as SHA-224: 64 words, 32-bit arithmetic.
